// File: rtl/m_imem_responder.sv
// m_imem_responder
//   Memory end of the PC-to-instruction fetch interface. Accepts one fetch
//   request at a time, models a fixed memory latency with a down-counter,
//   then presents the instruction word (or an error for a misaligned or
//   out-of-range address) until the fetch side takes it. A separate load
//   port writes program words at any time. Completed responses are counted.
//
// Ports
//   w_clk, w_rst_n      clock, asynchronous active-low reset
//   w_req_valid/ready   fetch request handshake, w_req_addr = byte address
//   w_rsp_valid/ready   response handshake, w_rsp_data / w_rsp_err payload
//   w_ld_we/addr/data   program load port (word index)
//   w_nrsp              completed response handshakes, wraps at 2^32
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; w_req_ready=1
// WAIT  | request captured, latency counter running down to 0
// RESP  | response registered and held; w_rsp_valid=1

module m_imem_responder #(
  parameter  int DEPTH   = 256,
  parameter  int LATENCY = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  input  logic          w_req_valid,
  input  logic [31:0]   w_req_addr,
  output logic          w_req_ready,
  output logic          w_rsp_valid,
  output logic [31:0]   w_rsp_data,
  output logic          w_rsp_err,
  input  logic          w_rsp_ready,
  input  logic          w_ld_we,
  input  logic [AW-1:0] w_ld_addr,
  input  logic [31:0]   w_ld_data,
  output logic [31:0]   w_nrsp
);

  // Counter only has to hold LATENCY-1; keep at least one bit for LATENCY=1.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic [31:0]   nrsp_q;
  logic          req_fire;
  logic          load_rsp;
  logic          rsp_fire;
  logic          addr_bad;

  logic [31:0]   mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_fire = 1'b0;
    load_rsp = 1'b0;
    rsp_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req_valid) begin
          req_fire = 1'b1;
          cnt_d    = CW'(LATENCY - 1);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          load_rsp = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (w_rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word index is compared at full width so any address bit above the
  // array, not just the next one up, flags the error.
  assign addr_bad = (addr_q[1:0] != 2'b00) ||
                    ({2'b00, addr_q[31:2]} >= 32'(DEPTH));

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      nrsp_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_fire) begin
        addr_q <= w_req_addr;
      end
      // Read of mem here sees the pre-edge contents, so a load-port write
      // on the same edge to the same word is returned as the old value.
      if (load_rsp) begin
        rsp_err_q  <= addr_bad;
        rsp_data_q <= addr_bad ? '0 : mem[addr_q[AW+1:2]];
      end
      if (rsp_fire) begin
        nrsp_q <= nrsp_q + 32'd1;
      end
    end
  end

  // Program storage is deliberately not reset; contents survive w_rst_n.
  always_ff @(posedge w_clk) begin
    if (w_ld_we) begin
      mem[w_ld_addr] <= w_ld_data;
    end
  end

  assign w_req_ready = (state_q == ST_IDLE);
  assign w_rsp_valid = (state_q == ST_RESP);
  assign w_rsp_data  = rsp_data_q;
  assign w_rsp_err   = rsp_err_q;
  assign w_nrsp      = nrsp_q;

endmodule
